serpent_en_round_seq: RTL

//  Iterative Serpent encryption sequencer. Owns the 128-bit block state and the round counter,

---
 rtl/serpent_en_round_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/serpent_en_round_seq.sv
// Iterative Serpent encryption sequencer: block state, round counter, key mixing and final whitening.
// Optional macro SERPENT_SEQ_ABORT_EN adds i_abort for a synchronous mid-block cancel.
module serpent_en_round_seq #(
    parameter int NUM_ROUNDS = 32,
    parameter int KEY_IDX_W  = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
`ifdef SERPENT_SEQ_ABORT_EN
    input  logic                 i_abort,
`endif
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [127:0]         i_data,
    output logic [KEY_IDX_W-1:0] o_key_idx,
    input  logic [127:0]         i_subkey,
    output logic [KEY_IDX_W-1:0] o_round,
    output logic [127:0]         o_round_data,
    input  logic [127:0]         i_round_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [127:0]         o_data
);

    localparam logic [KEY_IDX_W-1:0] LAST_RND = KEY_IDX_W'(NUM_ROUNDS);
    localparam logic [KEY_IDX_W-1:0] ONE      = KEY_IDX_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    seq_state_t           st;
    logic [KEY_IDX_W-1:0] rnd;
    logic [127:0]         blk;
    logic                 abort;

`ifdef SERPENT_SEQ_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    function automatic logic [127:0] key_mix(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st      <= IDLE;
            rnd     <= '0;
            blk     <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_data  <= '0;
        end else if (abort && st != IDLE) begin
            // Cancel wipes the block so no partial ciphertext lingers in the datapath.
            st      <= IDLE;
            rnd     <= '0;
            blk     <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_data  <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (i_valid && !abort) begin
                        blk     <= i_data;
                        rnd     <= ONE;
                        o_ready <= 1'b0;
                        st      <= RUN;
                    end
                end
                RUN: begin
                    blk <= i_round_data;
                    if (rnd == LAST_RND) begin
                        st <= DONE;
                    end else begin
                        rnd <= rnd + ONE;
                    end
                end
                DONE: begin
                    // First DONE cycle applies the final subkey; afterwards hold until taken.
                    if (!o_valid) begin
                        o_data  <= key_mix(blk, i_subkey);
                        o_valid <= 1'b1;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        rnd     <= '0;
                        st      <= IDLE;
                    end
                end
                default: begin
                    st      <= IDLE;
                    rnd     <= '0;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        o_key_idx    = '0;
        o_round      = '0;
        o_round_data = '0;
        case (st)
            RUN: begin
                o_key_idx    = rnd - ONE;
                o_round      = rnd;
                o_round_data = key_mix(blk, i_subkey);
            end
            DONE: begin
                o_key_idx = LAST_RND;
            end
            default: begin
            end
        endcase
    end

endmodule
